// File: rtl/lfsr_pkg.sv
// Shared constants and step functions for the parametrised LFSR generator.
// Functions operate on a zero-extended word so any width up to LFSR_MAX_W
// can reuse them; callers cast the result back to their own width.
package lfsr_pkg;

    localparam int LFSR_MAX_W = 64;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

    typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

    // Fibonacci: feedback parity of tapped bits enters at the top (bit width-1).
    // Inputs must be zero above width-1 so the right shift leaves that bit clear.
    function automatic lfsr_word_t fib_step(input lfsr_word_t seq,
                                            input lfsr_word_t poly,
                                            input int         width);
        lfsr_word_t fb;
        fb = lfsr_word_t'(^(seq & poly));
        return (seq >> 1) | (fb << (width - 1));
    endfunction

    // Galois: the bit shifted out of bit 0 toggles every tapped position.
    function automatic lfsr_word_t gal_step(input lfsr_word_t seq,
                                            input lfsr_word_t poly);
        return (seq >> 1) ^ ({LFSR_MAX_W{seq[0]}} & poly);
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational next-state unit: Fibonacci or Galois step, with recovery
// from the all-zero lock-up state back to INITIAL.
module lfsr_step #(
    parameter int           N       = 8,
    parameter logic [N-1:0] INITIAL = N'(1)
) (
    input  logic [N-1:0] seq,
    input  logic [N-1:0] char_poly,
    input  logic         galois,
    output logic [N-1:0] seq_n
);
    import lfsr_pkg::*;

    // Select the stepping formula; an all-zero register would never leave
    // zero under either formula, so it is forced back to INITIAL instead.
    always_comb begin
        seq_n = INITIAL;
        if (seq != '0) begin
            if (galois == MODE_GAL) begin
                seq_n = N'(gal_step(lfsr_word_t'(seq), lfsr_word_t'(char_poly)));
            end else begin
                seq_n = N'(fib_step(lfsr_word_t'(seq), lfsr_word_t'(char_poly), N));
            end
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator with load, step enable, runtime Fibonacci/Galois
// select, lock-up recovery and period measurement against the start value.
// The start value is whatever was last reset-loaded or seed-loaded; each step
// that lands back on it closes a period.
module lfsr_gen #(
    parameter int           N       = 8,
    parameter logic [N-1:0] INITIAL = N'(1)
) (
    input  logic         next,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] seed,
    input  logic         galois,
    input  logic [N-1:0] char_poly,
    output logic [N-1:0] seq,
    output logic         lockup,
    output logic [N-1:0] count,
    output logic [N-1:0] period,
    output logic         period_done
);
    import lfsr_pkg::*;

    logic [N-1:0] start;
    logic [N-1:0] seq_n;
    logic         match;
    logic [N-1:0] count_inc;

    lfsr_step #(
        .N       (N),
        .INITIAL (INITIAL)
    ) u_step (
        .seq       (seq),
        .char_poly (char_poly),
        .galois    (galois),
        .seq_n     (seq_n)
    );

    assign lockup    = (seq == '0);
    assign match     = (seq_n == start);
    // Saturate so an off-cycle start value cannot wrap the counter to zero
    // and fake a period.
    assign count_inc = (count == '1) ? count : count + N'(1);

    // Register update with priority load > step > hold.
    always_ff @(posedge next or negedge reset) begin
        if (!reset) begin
            seq         <= INITIAL;
            start       <= INITIAL;
            count       <= '0;
            period      <= '0;
            period_done <= 1'b0;
        end else if (load) begin
            seq         <= seed;
            start       <= seed;
            count       <= '0;
            period_done <= 1'b0;
        end else if (en) begin
            seq <= seq_n;
            if (match) begin
                period      <= count + N'(1);
                count       <= '0;
                period_done <= 1'b1;
            end else begin
                count       <= count_inc;
                period_done <= 1'b0;
            end
        end else begin
            period_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: an 8-bit instance for Fibonacci stepping and
// mode switching, a 4-bit instance for period, load, lock-up, hold, reset,
// period-of-one and count saturation.
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, en8, load8, gal8;
    logic [7:0] seed8, poly8, seq8, count8, period8;
    logic       lock8, pd8;

    logic       rst4, en4, load4, gal4;
    logic [3:0] seed4, poly4, seq4, count4, period4;
    logic       lock4, pd4;

    int n_vec = 0;
    int n_bad = 0;

    lfsr_gen #(.N(8), .INITIAL(8'h01)) u_dut8 (
        .next        (clk),
        .reset       (rst8),
        .en          (en8),
        .load        (load8),
        .seed        (seed8),
        .galois      (gal8),
        .char_poly   (poly8),
        .seq         (seq8),
        .lockup      (lock8),
        .count       (count8),
        .period      (period8),
        .period_done (pd8)
    );

    lfsr_gen #(.N(4), .INITIAL(4'h1)) u_dut4 (
        .next        (clk),
        .reset       (rst4),
        .en          (en4),
        .load        (load4),
        .seed        (seed4),
        .galois      (gal4),
        .char_poly   (poly4),
        .seq         (seq4),
        .lockup      (lock4),
        .count       (count4),
        .period      (period4),
        .period_done (pd4)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] fib8_exp [6]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h84};
    logic [3:0] fib4_exp [15] = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                                  4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
    logic [3:0] gal4_exp [15] = '{4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE, 4'h7,
                                  4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

    initial begin
        rst8 = 1'b0; en8 = 1'b0; load8 = 1'b0; gal8 = 1'b0; seed8 = '0; poly8 = 8'h09;
        rst4 = 1'b0; en4 = 1'b0; load4 = 1'b0; gal4 = 1'b0; seed4 = '0; poly4 = 4'h3;
        #12;
        check_val("rst8_seq", seq8, 8'h01);
        check_val("rst8_count", count8, 0);
        check_val("rst8_period", period8, 0);
        check_val("rst8_pd", pd8, 0);
        check_val("rst8_lock", lock8, 0);
        check_val("rst4_seq", seq4, 4'h1);
        rst8 = 1'b1;
        rst4 = 1'b1;

        // 8-bit Fibonacci stepping, poly 0x09
        en8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("fib8_seq", seq8, fib8_exp[i]);
            check_val("fib8_count", count8, i + 1);
        end

        // switch to Galois mid-run: 84 -> 42 -> 21 -> 19, count keeps going
        gal8 = 1'b1;
        tick(); check_val("sw_seq1", seq8, 8'h42); check_val("sw_count1", count8, 7);
        tick(); check_val("sw_seq2", seq8, 8'h21); check_val("sw_count2", count8, 8);
        tick(); check_val("sw_seq3", seq8, 8'h19); check_val("sw_count3", count8, 9);
        check_val("sw_period", period8, 0);
        en8 = 1'b0;

        // 4-bit Fibonacci period, poly 0x3
        en4 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_val("fib4_seq", seq4, fib4_exp[i]);
            check_val("fib4_pd", pd4, (i == 14) ? 1 : 0);
        end
        check_val("fib4_period", period4, 15);
        check_val("fib4_count", count4, 0);

        // 4-bit Galois period, poly 0xC, start still 1
        gal4 = 1'b1; poly4 = 4'hC;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_val("gal4_seq", seq4, gal4_exp[i]);
            check_val("gal4_pd", pd4, (i == 14) ? 1 : 0);
        end
        check_val("gal4_period", period4, 15);

        // load of zero beats en; then recovery to INITIAL
        load4 = 1'b1; seed4 = 4'h0;
        tick();
        check_val("ld0_seq", seq4, 0);
        check_val("ld0_lock", lock4, 1);
        check_val("ld0_count", count4, 0);
        check_val("ld0_period", period4, 15);
        load4 = 1'b0;
        tick();
        check_val("rec_seq", seq4, 4'h1);
        check_val("rec_lock", lock4, 0);
        check_val("rec_count", count4, 1);

        // period measured from a loaded start of 5 (Fibonacci, poly 3)
        load4 = 1'b1; seed4 = 4'h5; gal4 = 1'b0; poly4 = 4'h3;
        tick();
        check_val("ld5_seq", seq4, 4'h5);
        check_val("ld5_count", count4, 0);
        load4 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            check_val("ld5_pd", pd4, (i == 14) ? 1 : 0);
        end
        check_val("ld5_ret", seq4, 4'h5);
        check_val("ld5_period", period4, 15);

        // advance 5 -> A -> D -> E, then hold for 10 edges
        tick(); tick(); tick();
        check_val("pre_hold_seq", seq4, 4'hE);
        en4 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("hold_seq", seq4, 4'hE);
            check_val("hold_count", count4, 3);
            check_val("hold_pd", pd4, 0);
        end

        // asynchronous reset between edges
        #2;
        rst4 = 1'b0;
        #1;
        check_val("mrst_seq", seq4, 4'h1);
        check_val("mrst_count", count4, 0);
        check_val("mrst_period", period4, 0);
        check_val("mrst_pd", pd4, 0);
        rst4 = 1'b1;

        // period of one: Galois poly 1 maps 1 -> 1
        load4 = 1'b1; seed4 = 4'h1; gal4 = 1'b1; poly4 = 4'h1; en4 = 1'b1;
        tick();
        check_val("p1_pd_load", pd4, 0);
        load4 = 1'b0;
        tick();
        check_val("p1_pd1", pd4, 1);
        check_val("p1_period", period4, 1);
        check_val("p1_count", count4, 0);
        tick();
        check_val("p1_pd2", pd4, 1);
        en4 = 1'b0;
        tick();
        check_val("p1_pd_hold", pd4, 0);

        // off-cycle start 8 with poly 0: count saturates, no period pulse
        load4 = 1'b1; seed4 = 4'h8; poly4 = 4'h0;
        tick();
        load4 = 1'b0; en4 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_val("sat_pd", pd4, 0);
            if (i == 3) check_val("sat_lock", lock4, 1);
            if (i == 4) check_val("sat_recover", seq4, 4'h1);
        end
        check_val("sat_count", count4, 15);
        check_val("sat_period", period4, 1);
        en4 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
